// File: rtl/mult_div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mult_div_pkg
//  Purpose  : Shared op encodings, FSM state type and helpers for the
//             sequential multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package mult_div_pkg;

    // Operation encodings presented on op together with start
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Divide ops share the upper encoding bit
    function automatic logic is_div(input logic [1:0] op_i);
        return op_i[1];
    endfunction

    // Signed ops have the lower encoding bit clear
    function automatic logic is_signed_op(input logic [1:0] op_i);
        return ~op_i[0];
    endfunction

endpackage : mult_div_pkg
`default_nettype wire

// File: rtl/mult_div_signfix.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mult_div_signfix
//  Purpose  : Combinational sign handling. Input side turns raw operands into
//             magnitudes and result signs; output side re-applies the signs
//             to the unsigned product or quotient/remainder.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_signfix #(
    parameter int WIDTH = 32
) (
    // Input side: raw operands at acceptance time
    input  logic                 i_signed,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [WIDTH-1:0]     o_mag_a,
    output logic [WIDTH-1:0]     o_mag_b,
    output logic                 o_neg_q,
    output logic                 o_neg_r,
    // Output side: unsigned iteration result and latched signs
    input  logic                 i_fix_div,
    input  logic                 i_neg_q,
    input  logic                 i_neg_r,
    input  logic [2*WIDTH-1:0]   i_acc,
    output logic [WIDTH-1:0]     o_hi,
    output logic [WIDTH-1:0]     o_lo
);

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_quo;

    // Magnitude extraction; the minimum value maps onto itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        w_a_neg = i_signed & i_a[WIDTH-1];
        w_b_neg = i_signed & i_b[WIDTH-1];
        o_mag_a = w_a_neg ? (~i_a + 1'b1) : i_a;
        o_mag_b = w_b_neg ? (~i_b + 1'b1) : i_b;
        o_neg_q = w_a_neg ^ w_b_neg;
        o_neg_r = w_a_neg;
    end

    // Result sign restoration: full-width negate for products, per-half for
    // quotient (sign a^b) and remainder (sign of the dividend).
    always_comb begin
        w_prod = i_neg_q ? (~i_acc + 1'b1) : i_acc;
        w_rem  = i_neg_r ? (~i_acc[2*WIDTH-1:WIDTH] + 1'b1) : i_acc[2*WIDTH-1:WIDTH];
        w_quo  = i_neg_q ? (~i_acc[WIDTH-1:0] + 1'b1) : i_acc[WIDTH-1:0];
        if (i_fix_div) begin
            o_hi = w_rem;
            o_lo = w_quo;
        end else begin
            o_hi = w_prod[2*WIDTH-1:WIDTH];
            o_lo = w_prod[WIDTH-1:0];
        end
    end

endmodule : mult_div_signfix
`default_nettype wire

// File: rtl/mult_div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mult_div_seq
//  Purpose  : Multi-cycle signed/unsigned multiply and divide, one bit per
//             cycle, producing HI/LO with a done pulse and div-by-zero flag.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi_out,
    output logic [WIDTH-1:0]  lo_out,
    output logic              div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_opnd;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;       // mult: {partial, multiplier}; div: {rem, quotient}

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_neg_q;
    logic                 w_neg_r;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic                 w_accept;

    mult_div_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .i_signed  (is_signed_op(op)),
        .i_a       (a_in),
        .i_b       (b_in),
        .o_mag_a   (w_mag_a),
        .o_mag_b   (w_mag_b),
        .o_neg_q   (w_neg_q),
        .o_neg_r   (w_neg_r),
        .i_fix_div (r_is_div),
        .i_neg_q   (r_neg_q),
        .i_neg_r   (r_neg_r),
        .i_acc     (r_acc),
        .o_hi      (w_fix_hi),
        .o_lo      (w_fix_lo)
    );

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
        w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_opnd});
        // The true difference always fits in WIDTH bits when w_ge is set
        w_diff     = w_shift[WIDTH-1:0] - r_opnd;
        w_div_next = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
        w_accept   = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    end

    // Sequencer, iteration datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_opnd      <= '0;
            r_acc       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_is_div    <= is_div(op);
                        r_neg_q     <= w_neg_q;
                        r_neg_r     <= w_neg_r;
                        div_by_zero <= 1'b0;
                        if (is_div(op) && (b_in == '0)) begin
                            // Divide by zero completes immediately, hi/lo kept
                            r_state     <= ST_DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            busy    <= 1'b1;
                            r_cnt   <= CNT_W'(WIDTH);
                            r_opnd  <= is_div(op) ? w_mag_b : w_mag_a;
                            r_acc   <= {{WIDTH{1'b0}}, (is_div(op) ? w_mag_a : w_mag_b)};
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_out  <= w_fix_hi;
                    lo_out  <= w_fix_lo;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : mult_div_seq
`default_nettype wire

// File: tb/tb_mult_div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_seq
//  Purpose  : Self-checking bench for mult_div_seq with a behavioural model,
//             per-cycle compare process and directed literal vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_seq;

    localparam int WIDTH = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi_out;
    logic [WIDTH-1:0]  lo_out;
    logic              div_by_zero;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    mult_div_seq #(.WIDTH(WIDTH)) dut (
        .clock       (clk),
        .reset       (rst),
        .start       (start),
        .op          (op),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions
    function automatic void ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l);
        longint    sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                q = sa / sb;
                r = sa % sb;
                p = {32'(r), 32'(q)};
            end
            default: p = {a % b, a / b};
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    // Behavioural model: an accepted op finishes WIDTH+1 edges later;
    // a divide by zero finishes on the accepting edge.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic        m_dbz  = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [31:0] p_hi   = '0;
    logic [31:0] p_lo   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                end
            end else if (start) begin
                m_dbz = 1'b0;
                if (op[1] && b_in == '0) begin
                    m_done = 1'b1;
                    m_dbz  = 1'b1;
                end else begin
                    ref_calc(op, a_in, b_in, p_hi, p_lo);
                    m_left = WIDTH + 1;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("busy",        64'(busy),        64'(m_left > 0));
            chk("done",        64'(done),        64'(m_done));
            chk("hi",          64'(hi_out),      64'(m_hi));
            chk("lo",          64'(lo_out),      64'(m_lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        end
    end

    // Issue one op at the current negedge and wait (bounded) for done
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, output int lat, output int bcnt,
                          output logic [31:0] h, output logic [31:0] l, output logic z);
        bit seen;
        start = 1'b1; op = o; a_in = a; b_in = b;
        lat = 0; bcnt = 0; seen = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (poke && i == 5) begin
                start = 1'b1; op = 2'($urandom_range(0, 3));
                a_in = $urandom; b_in = $urandom | 32'h1;
            end
            if (poke && i == 6) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = i; seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
        h = hi_out; l = lo_out; z = div_by_zero;
    endtask

    function automatic logic [31:0] pick(input bit allow_zero);
        case ($urandom_range(0, 6))
            0: return allow_zero ? 32'h0 : 32'h1;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 15));
            4: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat, bcnt, cnt;
        logic [31:0] h, l;
        logic        z;

        start = 1'b0; op = '0; a_in = '0; b_in = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi",   64'(hi_out), 64'(0));
        chk("rst_lo",   64'(lo_out), 64'(0));
        chk("rst_dbz",  64'(div_by_zero), 64'(0));
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // 1: unsigned full-range multiply, latency and busy length
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt, h, l, z);
        chk("t1_hi", 64'(h), 64'hFFFF_FFFE);
        chk("t1_lo", 64'(l), 64'h0000_0001);
        chk("t1_lat", 64'(lat), 64'd34);
        chk("t1_busy_cycles", 64'(bcnt), 64'd33);
        @(negedge clk);
        chk("t1_done_one_cycle", 64'(done), 64'(0));

        // 2: signed multiply, then back-to-back start in the done cycle
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, lat, bcnt, h, l, z);
        chk("t2a_hi", 64'(h), 64'hFFFF_FFFF);
        chk("t2a_lo", 64'(l), 64'hFFFF_FFEB);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, lat, bcnt, h, l, z);
        chk("t2b_hi", 64'(h), 64'h4000_0000);
        chk("t2b_lo", 64'(l), 64'h0);
        chk("t2b_lat", 64'(lat), 64'd34);

        // 3: signed divide toward zero, then unsigned
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt, h, l, z);
        chk("t3a_lo", 64'(l), 64'hFFFF_FFFD);
        chk("t3a_hi", 64'(h), 64'hFFFF_FFFF);
        run_op(2'b11, 32'd7, 32'd2, 0, lat, bcnt, h, l, z);
        chk("t3b_lo", 64'(l), 64'd3);
        chk("t3b_hi", 64'(h), 64'd1);

        // 4: divide by zero keeps hi/lo and finishes immediately
        run_op(2'b11, 32'd5, 32'd0, 0, lat, bcnt, h, l, z);
        chk("t4_lat", 64'(lat), 64'd1);
        chk("t4_dbz", 64'(z), 64'd1);
        chk("t4_hi", 64'(h), 64'd1);
        chk("t4_lo", 64'(l), 64'd3);

        // 5: min / -1 wraps, with an ignored start during RUN
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, lat, bcnt, h, l, z);
        chk("t5_lo", 64'(l), 64'h8000_0000);
        chk("t5_hi", 64'(h), 64'h0);
        chk("t5_dbz", 64'(z), 64'd0);
        chk("t5_lat", 64'(lat), 64'd34);

        // 6: asynchronous reset mid-multiply
        @(negedge clk);
        start = 1'b1; op = 2'b01; a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_done", 64'(done), 64'(0));
        chk("t6_hi", 64'(hi_out), 64'(0));
        chk("t6_lo", 64'(lo_out), 64'(0));
        chk("t6_dbz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("t6_no_done", 64'(cnt), 64'(0));
        run_op(2'b00, 32'd6, 32'd7, 0, lat, bcnt, h, l, z);
        chk("t6_hi2", 64'(h), 64'h0);
        chk("t6_lo2", 64'(l), 64'd42);

        // Randomized traffic; the compare process checks every cycle
        for (int n = 0; n < 60; n++) begin
            run_op(2'($urandom_range(0, 3)), pick(1), pick(1), ($urandom_range(0, 7) == 0),
                   lat, bcnt, h, l, z);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mult_div_seq
`default_nettype wire
